// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - shared types, key codes and lookup helpers for the keypad scanner
package teclado_pkg;

    localparam int DEBOUNCE_MS_DEF = 20;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } estado_t;

    localparam logic [3:0] TEC_A   = 4'hA;
    localparam logic [3:0] TEC_B   = 4'hB;
    localparam logic [3:0] TEC_C   = 4'hC;
    localparam logic [3:0] TEC_D   = 4'hD;
    localparam logic [3:0] TEC_AST = 4'hE;
    localparam logic [3:0] TEC_NUM = 4'hF;

    // Lowest-indexed active-low row; only meaningful when some row is low
    function automatic logic [1:0] fila_baja(input logic [3:0] filas);
        if (!filas[0])      return 2'd0;
        else if (!filas[1]) return 2'd1;
        else if (!filas[2]) return 2'd2;
        else                return 2'd3;
    endfunction

    // Physical key position to key code
    function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] codigo;
        case ({fila, col})
            4'b00_00: codigo = 4'h1;
            4'b00_01: codigo = 4'h2;
            4'b00_10: codigo = 4'h3;
            4'b00_11: codigo = TEC_A;
            4'b01_00: codigo = 4'h4;
            4'b01_01: codigo = 4'h5;
            4'b01_10: codigo = 4'h6;
            4'b01_11: codigo = TEC_B;
            4'b10_00: codigo = 4'h7;
            4'b10_01: codigo = 4'h8;
            4'b10_10: codigo = 4'h9;
            4'b10_11: codigo = TEC_C;
            4'b11_00: codigo = TEC_AST;
            4'b11_01: codigo = 4'h0;
            4'b11_10: codigo = TEC_NUM;
            default:  codigo = TEC_D;
        endcase
        return codigo;
    endfunction

endpackage

// File: rtl/ensamblador_operandos.sv
// rtl/ensamblador_operandos.sv - builds divider operands and start pulse from accepted keys
module ensamblador_operandos
    import teclado_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic              clk1kHz,
    input  logic              rst_n,
    input  logic [3:0]        tecla,
    input  logic              tecla_valida,
    output logic [N_BITS-1:0] entrada,
    output logic [N_BITS-1:0] dividendo,
    output logic [N_BITS-1:0] divisor,
    output logic              start
);

    logic [N_BITS-1:0] entrada_q;
    logic [N_BITS-1:0] dividendo_q;
    logic [N_BITS-1:0] divisor_q;
    logic              start_q;

    // Apply each accepted key to the operand registers; start lasts one cycle
    always_ff @(posedge clk1kHz or negedge rst_n) begin
        if (!rst_n) begin
            entrada_q   <= '0;
            dividendo_q <= '0;
            divisor_q   <= '0;
            start_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (tecla_valida) begin
                case (tecla)
                    4'h0, 4'h1: entrada_q <= {entrada_q[N_BITS-2:0], tecla[0]};
                    TEC_A: begin
                        dividendo_q <= entrada_q;
                        entrada_q   <= '0;
                    end
                    TEC_B: begin
                        divisor_q <= entrada_q;
                        entrada_q <= '0;
                    end
                    TEC_C: entrada_q <= '0;
                    TEC_D: start_q <= 1'b1;
                    TEC_AST: begin
                        entrada_q   <= '0;
                        dividendo_q <= '0;
                        divisor_q   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign entrada   = entrada_q;
    assign dividendo = dividendo_q;
    assign divisor   = divisor_q;
    assign start     = start_q;

endmodule

// File: rtl/escaneo_teclado.sv
// rtl/escaneo_teclado.sv - 4x4 keypad column scanner with press/release debounce
module escaneo_teclado
    import teclado_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int N_BITS      = 8
) (
    input  logic              clk1kHz,
    input  logic              rst_n,
    input  logic [3:0]        filas,
    output logic [3:0]        columnas,
    output logic [3:0]        tecla,
    output logic              tecla_valida,
    output logic [N_BITS-1:0] entrada,
    output logic [N_BITS-1:0] dividendo,
    output logic [N_BITS-1:0] divisor,
    output logic              start
);

    // DEBOUNCE sees the first sample in SCAN, so it needs one count fewer than RELEASE
    localparam logic [7:0] LIM_DEB = 8'(DEBOUNCE_MS - 2);
    localparam logic [7:0] LIM_REL = 8'(DEBOUNCE_MS - 1);

    estado_t    estado_q;
    logic [1:0] col_q;
    logic [1:0] fila_q;
    logic [7:0] cnt_q;
    logic [3:0] columnas_q;
    logic [3:0] tecla_q;
    logic       valida_q;

    logic       hay_fila;
    logic [1:0] fila_act;

    // Current row sample: is any row pulled low, and which is the lowest one
    always_comb begin
        hay_fila = (filas != 4'hF);
        fila_act = fila_baja(filas);
    end

    // Scan/debounce FSM; columnas is rotated alongside col_q so it stays registered
    always_ff @(posedge clk1kHz or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= SCAN;
            col_q      <= 2'd0;
            fila_q     <= 2'd0;
            cnt_q      <= 8'd0;
            columnas_q <= 4'b1110;
            tecla_q    <= 4'h0;
            valida_q   <= 1'b0;
        end else begin
            valida_q <= 1'b0;
            case (estado_q)
                SCAN: begin
                    if (hay_fila) begin
                        fila_q   <= fila_act;
                        cnt_q    <= 8'd0;
                        estado_q <= DEBOUNCE;
                    end else begin
                        col_q      <= col_q + 2'd1;
                        columnas_q <= {columnas_q[2:0], columnas_q[3]};
                    end
                end
                DEBOUNCE: begin
                    if (hay_fila && (fila_act == fila_q)) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LIM_DEB) estado_q <= PRESSED;
                    end else begin
                        estado_q <= SCAN;
                    end
                end
                PRESSED: begin
                    tecla_q  <= codigo_tecla(fila_q, col_q);
                    valida_q <= 1'b1;
                    cnt_q    <= 8'd0;
                    estado_q <= RELEASE;
                end
                default: begin
                    if (hay_fila) begin
                        cnt_q <= 8'd0;
                    end else if (cnt_q == LIM_REL) begin
                        estado_q   <= SCAN;
                        col_q      <= col_q + 2'd1;
                        columnas_q <= {columnas_q[2:0], columnas_q[3]};
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign columnas     = columnas_q;
    assign tecla        = tecla_q;
    assign tecla_valida = valida_q;

    ensamblador_operandos #(
        .N_BITS(N_BITS)
    ) u_ensamblador (
        .clk1kHz     (clk1kHz),
        .rst_n       (rst_n),
        .tecla       (tecla_q),
        .tecla_valida(valida_q),
        .entrada     (entrada),
        .dividendo   (dividendo),
        .divisor     (divisor),
        .start       (start)
    );

endmodule

// File: tb/tb_escaneo_teclado.sv
// tb/tb_escaneo_teclado.sv - randomized keypad bench with behavioural model of keystroke handling
module tb_escaneo_teclado;

    localparam int D = 20;

    logic       clk1kHz = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] tecla;
    logic       tecla_valida;
    logic [7:0] entrada;
    logic [7:0] dividendo;
    logic [7:0] divisor;
    logic       start;

    always #5 clk1kHz = ~clk1kHz;

    escaneo_teclado #(
        .DEBOUNCE_MS(D),
        .N_BITS     (8)
    ) dut (
        .clk1kHz     (clk1kHz),
        .rst_n       (rst_n),
        .filas       (filas),
        .columnas    (columnas),
        .tecla       (tecla),
        .tecla_valida(tecla_valida),
        .entrada     (entrada),
        .dividendo   (dividendo),
        .divisor     (divisor),
        .start       (start)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Keypad: a held key pulls its row low while its column is driven low
    logic       held  = 1'b0;
    logic [1:0] k_row = 2'd0;
    logic [1:0] k_col = 2'd0;
    logic [3:0] mapa [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'hE, 4'h0, 4'hF, 4'hD}};

    always_comb begin
        filas = 4'hF;
        if (held && !columnas[k_col]) filas[k_row] = 1'b0;
    end

    // Requests from the stimulus; the checker catches up n_acc on each accepted key
    int         n_req   = 0;
    int         n_acc   = 0;
    logic [3:0] req_key = 4'h0;

    // Behavioural model state
    int         cyc = 0;
    int         det = -1;
    logic [7:0] m_ent = 8'h0, m_dvd = 8'h0, m_dvs = 8'h0;
    logic [3:0] m_tec = 4'h0;
    logic       m_start = 1'b0;
    int         n_start = 0;

    // Per-cycle check of every output against the model, sampled on the falling edge
    always @(negedge clk1kHz) begin
        logic       pend;
        logic       exp_pulse;
        logic [3:0] exp_tec;
        cyc++;
        if (!rst_n) begin
            m_ent = 8'h0; m_dvd = 8'h0; m_dvs = 8'h0;
            m_tec = 4'h0; m_start = 1'b0; det = -1;
        end else begin
            pend      = (n_req != n_acc);
            exp_pulse = pend && (det >= 0) && (cyc == det + D + 1);
            exp_tec   = exp_pulse ? req_key : m_tec;
            chk("columnas_onehot", 32'($countones(~columnas)), 32'd1);
            chk("tecla_valida", 32'(tecla_valida), 32'(exp_pulse));
            chk("tecla", 32'(tecla), 32'(exp_tec));
            chk("entrada", 32'(entrada), 32'(m_ent));
            chk("dividendo", 32'(dividendo), 32'(m_dvd));
            chk("divisor", 32'(divisor), 32'(m_dvs));
            chk("start", 32'(start), 32'(m_start));
            if (start) n_start++;
            m_tec   = exp_tec;
            m_start = 1'b0;
            if (exp_pulse) begin
                case (req_key)
                    4'h0, 4'h1: m_ent = {m_ent[6:0], req_key[0]};
                    4'hA: begin m_dvd = m_ent; m_ent = 8'h0; end
                    4'hB: begin m_dvs = m_ent; m_ent = 8'h0; end
                    4'hC: m_ent = 8'h0;
                    4'hD: m_start = 1'b1;
                    4'hE: begin m_ent = 8'h0; m_dvd = 8'h0; m_dvs = 8'h0; end
                    default: ;
                endcase
                n_acc = n_req;
                det   = -1;
            end
            if ((n_req != n_acc) && (det < 0) && (filas != 4'hF)) det = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk1kHz);
            #2;
        end
    endtask

    task automatic locate(input logic [3:0] code);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mapa[r][c] == code) begin
                    k_row = 2'(r);
                    k_col = 2'(c);
                end
    endtask

    task automatic press(input logic [3:0] code, input bit bounce);
        locate(code);
        if (bounce) begin
            for (int i = 0; i < 10; i++) begin
                held = 1'($urandom_range(0, 1));
                tick(1);
            end
            held = 1'b0;
            tick(3);
        end
        req_key = code;
        n_req++;
        held = 1'b1;
        tick(D + 6 + $urandom_range(0, 6));
        held = 1'b0;
        tick(D + 5 + $urandom_range(0, 4));
        chk("key_accepted", 32'(n_acc), 32'(n_req));
    endtask

    task automatic check_reset_values();
        chk("rst_columnas", 32'(columnas), 32'h0000000E);
        chk("rst_tecla", 32'(tecla), 32'd0);
        chk("rst_valida", 32'(tecla_valida), 32'd0);
        chk("rst_entrada", 32'(entrada), 32'd0);
        chk("rst_dividendo", 32'(dividendo), 32'd0);
        chk("rst_divisor", 32'(divisor), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
    endtask

    initial begin
        logic [3:0] rot [4];
        logic [3:0] seq_op [12];
        int         guard;
        rot    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seq_op = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'hA, 4'h1, 4'h1, 4'hB};

        // Reset and idle rotation
        @(posedge clk1kHz);
        #2;
        check_reset_values();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk1kHz);
            #1;
            chk("idle_columnas", 32'(columnas), 32'(rot[i % 4]));
            chk("idle_valida", 32'(tecla_valida), 32'd0);
        end
        tick(1);

        // Single press of key 6, then a bounced key 5
        press(4'h6, 1'b0);
        chk("single_tecla", 32'(tecla), 32'h6);
        press(4'h5, 1'b1);
        chk("bounce_tecla", 32'(tecla), 32'h5);

        // Full operation: dividend 0xC8, divisor 0x03, then start
        press(4'hE, 1'b0);
        foreach (seq_op[i]) press(seq_op[i], 1'b0);
        guard = n_start;
        press(4'hD, 1'b0);
        chk("op_dividendo", 32'(dividendo), 32'hC8);
        chk("op_divisor", 32'(divisor), 32'h03);
        chk("op_entrada", 32'(entrada), 32'h00);
        chk("op_start_count", 32'(n_start - guard), 32'd1);

        // Nine ones saturate the shift register, then clear
        for (int i = 0; i < 9; i++) press(4'h1, 1'b0);
        chk("shift_entrada", 32'(entrada), 32'hFF);
        press(4'hC, 1'b0);
        chk("clear_entrada", 32'(entrada), 32'h00);
        press(4'hE, 1'b0);
        chk("ast_dividendo", 32'(dividendo), 32'h00);
        chk("ast_divisor", 32'(divisor), 32'h00);

        // Randomized keystrokes
        for (int i = 0; i < 24; i++)
            press(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

        // Asynchronous reset in the middle of a debounce
        press(4'h1, 1'b0);
        locate(4'h8);
        req_key = 4'h8;
        n_req++;
        held  = 1'b1;
        guard = 0;
        while (det < 0 && guard < 20) begin
            tick(1);
            guard++;
        end
        chk("reset_detect_timeout", 32'(det >= 0), 32'd1);
        tick(D / 2);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        tick(3);
        rst_n = 1'b1;
        tick(D + 10);
        held = 1'b0;
        tick(D + 5);
        chk("reset_held_accepted", 32'(n_acc), 32'(n_req));
        chk("reset_held_tecla", 32'(tecla), 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
